// File: rtl/tx_pkg.sv
// tx_pkg: power FSM states, config register reset and field positions shared by the tx block
package tx_pkg;
  typedef enum logic [1:0] {ACTIVE, COUNT, IDLE} pwr_e;
  localparam logic [6:0] IDLE_RST_DEF = 7'd1;
  localparam int EN_BIT = 0;
  localparam int IDLE_LSB = 1;
  localparam int IDLE_MSB = 7;
  function automatic logic [7:0] cfg_rst(input logic [6:0] idle_time);
    return {idle_time, 1'b0};
  endfunction
endpackage

// File: rtl/tx_if.sv
// tx_if: memory-side, requestor-side, config and power signals of tx; tx_level exists only with TX_LEVEL_EN
interface tx_if #(parameter int DEPTH = 4);
  logic                   tx_mem;
  logic [7:0]             tx_mem_data;
  logic                   tx_mem_rdy;
  logic                   tx_vld;
  logic [7:0]             tx_data;
  logic                   tx_rdy;
  logic                   reg_wr;
  logic [7:0]             reg_data;
  logic                   idle;
`ifdef TX_LEVEL_EN
  logic [$clog2(DEPTH):0] tx_level;
  modport master (output tx_mem, tx_mem_data, tx_rdy, reg_wr, reg_data,
                  input tx_mem_rdy, tx_vld, tx_data, idle, tx_level);
  modport slave  (input tx_mem, tx_mem_data, tx_rdy, reg_wr, reg_data,
                  output tx_mem_rdy, tx_vld, tx_data, idle, tx_level);
`else
  modport master (output tx_mem, tx_mem_data, tx_rdy, reg_wr, reg_data,
                  input tx_mem_rdy, tx_vld, tx_data, idle);
  modport slave  (input tx_mem, tx_mem_data, tx_rdy, reg_wr, reg_data,
                  output tx_mem_rdy, tx_vld, tx_data, idle);
`endif
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with wrapping pointers and occupancy count; count_o exists only with TX_LEVEL_EN
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_i,
  input  logic [7:0]             wdata_i,
  input  logic                   rd_i,
  output logic [7:0]             rdata_o,
  output logic                   full_o,
`ifdef TX_LEVEL_EN
  output logic [$clog2(DEPTH):0] count_o,
`endif
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  assign rdata_o = mem_q[rp_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
`ifdef TX_LEVEL_EN
  assign count_o = cnt_q;
`endif
  always_comb begin
    wp_d  = wp_q + AW'(wr_i);
    rp_d  = rp_q + AW'(rd_i);
    cnt_d = cnt_q + (AW+1)'(wr_i) - (AW+1)'(rd_i);
  end
  always_ff @(posedge clk) if (wr_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tx.sv
// tx: transmit FIFO with config register, idle timer and power FSM; TX_LEVEL_EN adds the tx_level output
module tx import tx_pkg::*; #(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] IDLE_RST = IDLE_RST_DEF
) (
  input logic clk,
  input logic reset_n,
  tx_if.slave bus
);
  logic [7:0] cfg_q, cfg_d;
  logic [6:0] timer_q, timer_d, idle_time;
  pwr_e       state_q, state_d;
  logic       idle_q, wr, rd, full, empty;
  assign idle_time      = cfg_q[IDLE_MSB:IDLE_LSB];
  assign bus.tx_mem_rdy = cfg_q[EN_BIT] && !full;
  assign bus.tx_vld     = !empty;
  assign bus.idle       = idle_q;
  assign wr             = bus.tx_mem && bus.tx_mem_rdy;
  assign rd             = bus.tx_vld && bus.tx_rdy;
  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_i    (wr),
    .wdata_i (bus.tx_mem_data),
    .rd_i    (rd),
    .rdata_o (bus.tx_data),
    .full_o  (full),
`ifdef TX_LEVEL_EN
    .count_o (bus.tx_level),
`endif
    .empty_o (empty)
  );
  always_comb begin
    cfg_d   = bus.reg_wr ? bus.reg_data : cfg_q;
    timer_d = (wr || !empty) ? idle_time : timer_q - 7'(timer_q != '0);
    state_d = state_q;
    case (state_q)
      ACTIVE:  state_d = (empty && !wr) ? COUNT : ACTIVE;
      COUNT:   state_d = wr ? ACTIVE : (timer_q == '0 && empty && !bus.tx_mem) ? IDLE : COUNT;
      IDLE:    state_d = (bus.tx_mem || !empty) ? ACTIVE : IDLE;
      default: state_d = ACTIVE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cfg_q   <= cfg_rst(IDLE_RST);
      timer_q <= IDLE_RST;
      state_q <= ACTIVE;
      idle_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      timer_q <= timer_d;
      state_q <= state_d;
      idle_q  <= state_d == IDLE;
    end
endmodule

// File: doc/tx.md
# tx

Transmit-side datapath block: accepts bytes from the memory controller, buffers them in a small FIFO, and presents them to the requestor over a valid/ready handshake. It is the return-direction counterpart of the receive block and shares its register format and idle/power-down signalling toward the power controller.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- IDLE_RST, 7'd1: reset value of idle_time; nonzero, which prevents shutdown immediately after reset.
- clk  in  1  clock; all state is updated on the rising edge.
- reset_n  in  1  reset; one clock domain, asynchronous, active-low.
- tx_mem  in  1  memory controller has a byte on tx_mem_data.
- tx_mem_data  in  8  byte from the memory controller.
- tx_mem_rdy  out  1  block can accept a byte this cycle.
- tx_vld  out  1  tx_data is valid toward the requestor.
- tx_data  out  8  byte toward the requestor.
- tx_rdy  in  1  requestor accepts tx_data this cycle.
- reg_wr  in  1  configuration register write strobe.
- reg_data  in  8  configuration value, formatted as {idle_time[6:0], tx_enable}.
- idle  out  1  block is idle; used by the power controller.

## Operation
- Config register:
  - Reset value: {IDLE_RST, 1'b0}, so tx_enable=0 after reset.
  - On reg_wr, the register loads reg_data on the next edge.
- Write (accept from memory controller):
  - tx_mem_rdy = tx_enable && !full, combinational from registered state.
  - A write occurs when tx_mem && tx_mem_rdy; tx_mem_data is stored at the tail.
- Read (send to requestor):
  - tx_vld = !empty; tx_data = head entry, taken from storage.
  - A read occurs when tx_vld && tx_rdy; the head advances.
- tx_vld is never dropped before acceptance. tx_data is stable while tx_vld && !tx_rdy.
- Disable (tx_enable=0): no new writes are accepted. Entries already queued still drain to the requestor.
- Full: tx_mem_rdy=0, including on a cycle where a read occurs; there is no pass-through.
- Empty: a write is visible as tx_vld on the next cycle. Empty-cycle writes are never bypassed to the output.
- Simultaneous read and write when not full and not empty: count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, natural wrap. Count: log2(DEPTH)+1 bits.
- Idle timer (7 bits), checked in this order:
  - on a write: load idle_time;
  - else, if the FIFO is non-empty: load idle_time;
  - else, if the timer is nonzero: decrement.
- Power FSM (2-bit state):
  - ACTIVE -> COUNT when the FIFO is empty and there is no write.
  - COUNT -> IDLE when timer==0 && empty && !tx_mem.
  - COUNT -> ACTIVE on a write.
  - IDLE -> ACTIVE on tx_mem or !empty.
  - idle is registered and equals 1 exactly while the FSM is in IDLE.
- idle_time=0 is legal. The timer then stays 0, and IDLE is entered one cycle after the FIFO empties with tx_mem low.

## Timing
- Reset values: tx_vld=0, tx_mem_rdy=0, idle=0, FSM=ACTIVE, timer=IDLE_RST, pointers=0, count=0. tx_data is undefined while tx_vld=0.
- Latency from a write to tx_vld is 1 cycle. Throughput is 1 byte/cycle in steady state.
- idle asserts at the earliest 1 cycle after the cycle in which timer==0, empty and !tx_mem all hold.
- idle deasserts 1 cycle after tx_mem rises. tx_mem_rdy does not depend on idle.
- reset_n asserted mid-transfer: FIFO contents are discarded. Outputs take their reset values asynchronously, and tx_vld drops immediately.

## Configuration
- TX_LEVEL_EN:
  - Defined: adds output tx_level [log2(DEPTH):0], equal to the registered FIFO count (reset 0).
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package tx_pkg holds:
  - the power FSM state typedef (ACTIVE, COUNT, IDLE);
  - the reset constant for the config register;
  - the field positions within reg_data.
- Sub-module tx_fifo holds the storage, pointers, count, full and empty. The top level holds the config register, idle timer, power FSM and handshake gating.

## Test plan
- After reset, write reg_data=8'h0B (idle_time=5, enable=1); push 0xA5 with tx_rdy=1 -> tx_vld high 1 cycle later with tx_data=0xA5; tx_mem_rdy stays 1.
- tx_rdy=0; push 5 bytes 0x01..0x05 with DEPTH=4 -> tx_mem_rdy drops after the 4th byte; 0x05 is held off. Then tx_rdy=1 -> 0x01..0x05 delivered in order with no gaps.
- FIFO full, tx_rdy=1, tx_mem=1 on the same cycle -> one read, no write. The write succeeds on the next cycle, and count returns to 4.
- idle_time=5, FIFO drains, tx_mem=0 -> idle rises 6-7 cycles after empty. Raising tx_mem -> idle falls the next cycle, and the FSM goes to ACTIVE.
- Write reg_data=8'h0A (enable=0) with 2 bytes queued -> tx_mem_rdy=0 immediately; both bytes still delivered.
- Assert reset_n low with 3 bytes queued -> tx_vld drops the same cycle; after release, tx_vld=0, idle=0, tx_level=0 (with TX_LEVEL_EN).
